// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, type_o bit indices, decode record and opcode classifier for decode_stage
package decode_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam int T_R      = 0;
   localparam int T_I      = 1;
   localparam int T_LOAD   = 2;
   localparam int T_STORE  = 3;
   localparam int T_BRANCH = 4;
   localparam int T_JALR   = 5;
   localparam int T_JAL    = 6;
   localparam int T_LUI    = 7;
   localparam int T_AUIPC  = 8;
   localparam int T_FENCE  = 9;
   localparam int T_SYSTEM = 10;
   localparam int NTYPE    = 11;

   typedef struct packed {
      logic [NTYPE-1:0] typ;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [2:0]       funct3;
      logic             funct7b5;
      logic             illegal;
   } dec_t;

   // Every opcode ends in 2'b11, so a full 7-bit match also rejects compressed encodings
   function automatic logic [NTYPE-1:0] classify(input logic [6:0] op, input logic ext);
      logic [NTYPE-1:0] t;
      t           = '0;
      t[T_R]      = op == OP_R;
      t[T_I]      = op == OP_I;
      t[T_LOAD]   = op == OP_LOAD;
      t[T_STORE]  = op == OP_STORE;
      t[T_BRANCH] = op == OP_BRANCH;
      t[T_JALR]   = op == OP_JALR;
      t[T_JAL]    = op == OP_JAL;
      t[T_LUI]    = op == OP_LUI;
      t[T_AUIPC]  = ext && op == OP_AUIPC;
      t[T_FENCE]  = ext && op == OP_FENCE;
      t[T_SYSTEM] = ext && op == OP_SYSTEM;
      return t;
   endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate for the decoded instruction class (zero when no immediate)
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]        instr,
   input  logic [T_AUIPC:T_I] typ,
   output logic [XLEN-1:0]    imm
);
   logic [31:0] i32;

   // Pick the format by class, then sign-extend the 32-bit value to XLEN
   always_comb begin
      i32 = (typ[T_I] | typ[T_LOAD] | typ[T_JALR]) ? {{20{instr[31]}}, instr[31:20]}
          : typ[T_STORE]  ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
          : typ[T_BRANCH] ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
          : typ[T_JAL]    ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
          : (typ[T_LUI] | typ[T_AUIPC]) ? {instr[31:12], 12'b0}
          : '0;
      imm = XLEN'($signed(i32));
   end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: combinational RV32 decode into a DEPTH-entry FIFO; define DECODE_EXT_EN to decode AUIPC/FENCE/SYSTEM
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic [31:0]      instr_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [NTYPE-1:0] type_o,
   output logic [4:0]       rd_o,
   output logic [4:0]       rs1_o,
   output logic [4:0]       rs2_o,
   output logic [2:0]       funct3_o,
   output logic             funct7b5_o,
   output logic [XLEN-1:0]  imm_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] ill_cnt_o
);
   localparam int AW = $clog2(DEPTH);
`ifdef DECODE_EXT_EN
   localparam logic EXT = 1'b1;
`else
   localparam logic EXT = 1'b0;
`endif

   dec_t            mem     [DEPTH];
   logic [XLEN-1:0] imm_mem [DEPTH];
   dec_t            dec;
   logic [XLEN-1:0] imm;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     cnt;
   logic            up, full, push, pop;

   // Decode the incoming word into the record that gets buffered
   always_comb begin
      dec.typ      = classify(instr_i[6:0], EXT);
      dec.rd       = instr_i[11:7];
      dec.rs1      = instr_i[19:15];
      dec.rs2      = instr_i[24:20];
      dec.funct3   = instr_i[14:12];
      dec.funct7b5 = instr_i[30];
      dec.illegal  = ~|dec.typ;
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr(instr_i[31:7]),
      .typ  (dec.typ[T_AUIPC:T_I]),
      .imm  (imm)
   );

   // up keeps ready_o low until the first edge after reset release
   assign full    = cnt == (AW+1)'(DEPTH);
   assign ready_o = up && !full;
   assign valid_o = cnt != '0;
   assign push    = valid_i && ready_o && !flush_i;
   assign pop     = valid_o && ready_i && !flush_i;

   // Pointer/occupancy control; flush beats push/pop but leaves the illegal counter alone
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         up        <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         ill_cnt_o <= '0;
      end else begin
         up <= 1'b1;
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            cnt    <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         end
         if (push && dec.illegal && !(&ill_cnt_o)) ill_cnt_o <= ill_cnt_o + CNT_W'(1);
      end
   end

   // Entry storage needs no reset; occupancy alone qualifies it
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr]     <= dec;
         imm_mem[wr_ptr] <= imm;
      end
   end

   assign type_o     = mem[rd_ptr].typ;
   assign rd_o       = mem[rd_ptr].rd;
   assign rs1_o      = mem[rd_ptr].rs1;
   assign rs2_o      = mem[rd_ptr].rs2;
   assign funct3_o   = mem[rd_ptr].funct3;
   assign funct7b5_o = mem[rd_ptr].funct7b5;
   assign illegal_o  = mem[rd_ptr].illegal;
   assign imm_o      = imm_mem[rd_ptr];
endmodule
